// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared state encoding and default constants for add_sequencer
package add_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GET_A  = 3'd1,
      GET_B  = 3'd2,
      SETTLE = 3'd3,
      SHOW   = 3'd4
   } state_t;

   localparam int DEFAULT_SETTLE_CYCLES = 2;
   localparam int DEFAULT_SYNC_STAGES   = 2;
   localparam int CNT_W                 = 4;

endpackage

// File: rtl/key_press_detect.sv
// rtl/key_press_detect.sv - synchroniser chain plus falling-edge pulse for an active-low key
module key_press_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Flops reset to 1 so a released button produces no spurious edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign press = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/add_sequencer.sv
// rtl/add_sequencer.sv - operand entry / settle / capture sequencer for the ripple adder datapath
// Build option ADD_SEQ_SIGNED_OVF_EN selects two's-complement overflow instead of carry-out.
module add_sequencer
   import add_seq_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             enter_n,
   input  logic             chain,
   input  logic [WIDTH-1:0] operand_in,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             cout_in,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             done,
   output logic [2:0]       state_code
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               press;
   logic               load_a, load_b, chain_a, clear_ops, capture, clear_done;
   logic               ovf_d;

   key_press_detect #(.SYNC_STAGES(SYNC_STAGES)) u_key (
      .clk   (Clock),
      .reset (Reset),
      .key_n (enter_n),
      .press (press)
   );

`ifdef ADD_SEQ_SIGNED_OVF_EN
   assign ovf_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_in[WIDTH-1] != op_a[WIDTH-1]);
`else
   assign ovf_d = cout_in;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Presses outside GET_A/GET_B/SHOW fall through unused, so nothing queues during SETTLE.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      load_a     = 1'b0;
      load_b     = 1'b0;
      chain_a    = 1'b0;
      clear_ops  = 1'b0;
      capture    = 1'b0;
      clear_done = 1'b0;
      case (state_q)
         IDLE: state_d = GET_A;
         GET_A: begin
            if (press) begin
               load_a  = 1'b1;
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (press) begin
               load_b  = 1'b1;
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = SHOW;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SHOW: begin
            if (press) begin
               clear_done = 1'b1;
               if (chain) begin
                  chain_a = 1'b1;
                  state_d = GET_B;
               end else begin
                  clear_ops = 1'b1;
                  state_d   = GET_A;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         op_a     <= '0;
         op_b     <= '0;
         result   <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (load_a)         op_a <= operand_in;
         else if (chain_a)   op_a <= result;
         else if (clear_ops) op_a <= '0;

         if (load_b)         op_b <= operand_in;
         else if (clear_ops) op_b <= '0;

         if (capture) begin
            result   <= sum_in;
            overflow <= ovf_d;
            done     <= 1'b1;
         end else if (clear_done) begin
            done <= 1'b0;
         end
      end
   end

   assign state_code = state_q;

endmodule
